// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption core. It performs one cipher round per
// round key delivered on the key request handshake and holds the result until it is consumed.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  input  logic         abort
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] KEY0  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + r) % 4) + r;
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*src -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [2:0]   fsm_p0;
  logic [127:0] blk_p0;
  logic [3:0]   cnt_p0;
  logic [3:0]   cnt_inc;
  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;

  assign sb_out  = sub_bytes(blk_p0);
  assign sr_out  = shift_rows(sb_out);
  assign mc_out  = mix_columns(sr_out);
  assign cnt_inc = cnt_p0 + 4'd1;

  // Round sequencing: abort wins over every handshake; each key stage waits for key_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_p0 <= IDLE;
      blk_p0 <= '0;
      cnt_p0 <= '0;
    end else if (abort) begin
      fsm_p0 <= IDLE;
      cnt_p0 <= '0;
    end else begin
      case (fsm_p0)
        IDLE: begin
          if (in_valid) begin
            blk_p0 <= data_in;
            cnt_p0 <= '0;
            fsm_p0 <= KEY0;
          end
        end
        KEY0: begin
          if (key_valid) begin
            blk_p0 <= blk_p0 ^ key_in;
            cnt_p0 <= 4'd1;
            fsm_p0 <= (LAST_RND == 4'd1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          if (key_valid) begin
            blk_p0 <= mc_out ^ key_in;
            cnt_p0 <= cnt_inc;
            if (cnt_inc == LAST_RND) fsm_p0 <= FINAL;
          end
        end
        FINAL: begin
          if (key_valid) begin
            blk_p0 <= sr_out ^ key_in;
            fsm_p0 <= DONE;
          end
        end
        DONE: begin
          if (out_ready) fsm_p0 <= IDLE;
        end
        default: fsm_p0 <= IDLE;
      endcase
    end
  end

  // Handshake outputs and the requested key index decode straight from the FSM state.
  always_comb begin
    key_idx = 4'd0;
    case (fsm_p0)
      ROUND:   key_idx = cnt_p0;
      FINAL:   key_idx = LAST_RND;
      default: key_idx = 4'd0;
    endcase
  end

  assign in_ready  = (fsm_p0 == IDLE);
  assign key_req   = (fsm_p0 == KEY0) || (fsm_p0 == ROUND) || (fsm_p0 == FINAL);
  assign out_valid = (fsm_p0 == DONE);
  assign data_out  = blk_p0;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds after the initial AddRoundKey; legal values are 10, 12 and 14.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning a block is offered on data_in.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a new input.
REQ-006 SHALL have port data_in, input, 128, the plaintext block; byte 0 sits in bits [127:120], and the state is column-major.
REQ-007 SHALL have port key_req, output, 1, meaning a round key is requested.
REQ-008 SHALL have port key_idx, output, 4, the index of the requested round key, 0..NUM_ROUNDS.
REQ-009 SHALL have port key_valid, input, 1, meaning key_in holds round key key_idx.
REQ-010 SHALL have port key_in, input, 128, the round key, in the same byte order as data_in.
REQ-011 SHALL have port out_valid, output, 1, meaning data_out holds the ciphertext.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer accepts data_out.
REQ-013 SHALL have port data_out, output, 128, driven continuously from the internal state register.
REQ-014 SHALL have port abort, input, 1, a synchronous cancel of the operation in flight.

Function
REQ-015 SHALL build the round datapath from the team's combinational SubBytes, ShiftRows and MixColumns blocks, followed by a 128-bit XOR for AddRoundKey.
REQ-016 SHALL implement the FSM states IDLE, KEY0, ROUND, FINAL and DONE.
REQ-017 IDLE: in_ready=1 and key_req=0; when in_valid=1, SHALL load data_in into the state register, clear the round counter to 0 and go to KEY0.
REQ-018 KEY0: key_req=1, key_idx=0; on key_valid SHALL set state = state XOR key_in, set the counter to 1, and go to ROUND, or to FINAL when NUM_ROUNDS=1 (used only by the bench).
REQ-019 ROUND: key_req=1, key_idx=counter; on key_valid SHALL set state = MixColumns(ShiftRows(SubBytes(state))) XOR key_in and increment the counter.
REQ-020 ROUND SHALL go to FINAL when the counter reaches NUM_ROUNDS after increment, and SHALL otherwise stay in ROUND.
REQ-021 FINAL: key_req=1, key_idx=NUM_ROUNDS; on key_valid SHALL set state = ShiftRows(SubBytes(state)) XOR key_in and go to DONE.
REQ-022 DONE: out_valid=1 and data_out stable; when out_ready=1, SHALL go to IDLE.
REQ-023 in_ready SHALL be 1 only in IDLE, so back-to-back blocks are separated by at least one IDLE cycle.
REQ-024 When key_valid is held high, a block accepted at edge E SHALL reach out_valid=1 in the cycle after edge E+NUM_ROUNDS+1, a latency of 12 cycles for NUM_ROUNDS=10.
REQ-025 While key_req=1 and key_valid=0, the state register, counter and key_idx SHALL hold unchanged, with no timeout.
REQ-026 key_valid while key_req=0 SHALL be ignored.
REQ-027 in_valid outside IDLE SHALL be ignored and SHALL not be queued.
REQ-028 abort=1 in any state SHALL force IDLE at the next edge and clear the counter; abort takes priority over key_valid, out_ready and in_valid in the same cycle.
REQ-029 abort SHALL leave the state register unchanged, and out_valid SHALL be 0 from the next cycle.
REQ-030 In DONE, out_ready=1 together with in_valid=1 SHALL complete the output only; the new block is accepted in the following IDLE cycle.
REQ-031 The counter SHALL be 4 bits wide and SHALL never exceed NUM_ROUNDS, with no wrap-around.
REQ-032 key_idx SHALL be 0 whenever key_req=0.

Reset
REQ-033 rst=0 SHALL set the FSM to IDLE immediately, without waiting for a clock edge.
REQ-034 rst=0 SHALL clear the state register, counter and key_idx to 0, making in_ready=1 and key_req=0.
REQ-035 rst=0 SHALL drive out_valid=0 and data_out=128'h0.
REQ-036 rst=0 asserted mid-operation SHALL discard the block in flight, with no output produced.
REQ-037 After rst returns to 1, the block SHALL accept a new input on the first rising edge with in_valid=1.

Verification
REQ-038 Run the FIPS-197 C.1 vector: data_in=00112233445566778899aabbccddeeff, and the bench key model supplies the expanded keys of 000102030405060708090a0b0c0d0e0f with key_valid=1 → the state after KEY0 is 00102030405060708090a0b0c0d0e0f0, data_out=69c4e0d86a7b0430d8cdb78070b4c55a, and out_valid rises 12 cycles after accept.
REQ-039 Repeat the same vector with key_valid stalled 3 cycles at key_idx=5 and 1 cycle at key_idx=10 → same ciphertext, latency 16 cycles, and key_idx holds at 5 during the stall.
REQ-040 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 → data_out stays stable, in_ready=0, and no second block is accepted until the cycle after out_ready=1.
REQ-041 Assert abort at key_idx=4 → IDLE on the next cycle, out_valid never rises, and a following vector yields the correct ciphertext.
REQ-042 Drop rst to 0 between edges at key_idx=7 → out_valid=0, data_out=0 and in_ready=1 immediately, before the next edge.
REQ-043 Pulse key_valid in IDLE and in DONE → no change to the state register or counter.
